imem_fetch_resp: RTL and testbench

Instruction-memory responder for the IF stage: serves the fetch address held by the program counter, returns the 32-bit instruction word after a fixed number of wait states, and drives a stall that holds the PC while a fetch is outstanding. It contains a word-addressed instruction RAM based at word address 30'h0000C00 (byte 0x3000), which a side write port can preload. A flush aborts an in-flight fetch on branch redirect.

---
 rtl/imem_fetch_resp.sv | 165 ++++++++++++++++
 tb/tb_imem_fetch_resp.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: instruction-memory responder for the IF stage.
// Accepts one fetch at a time from the PC, waits LATENCY cycles, then pulses
// rsp_valid for one cycle with the instruction word. stall holds the PC while
// a fetch is outstanding. The word-addressed RAM is based at word BASE and can
// be preloaded through an independent write port. A flush aborts a fetch that
// is still waiting.
// Optional feature macro: IMEM_RANGE_CHECK_EN
//   defined   - fetches whose index falls outside the RAM return a nop with
//               fault=1, and out-of-range writes are dropped.
//   undefined - the index wraps to its low ADDR_W bits, fault is always 0.

module imem_fetch_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter logic [29:0] BASE    = 30'h0000C00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:2] req_addr,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:2] wr_addr,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:2] rsp_addr,
  output logic        fault
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;

  logic        accept;
  logic        enter_resp;
  logic [29:0] rd_addr;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic        wr_ok;

  logic [31:0] mem [DEPTH];

  // A request is taken only from IDLE and only when no flush is present;
  // flush wins over a simultaneous request.
  assign accept = (state_q == IDLE) & req_valid & ~flush;

  // With zero wait states the RAM is read on the accept edge itself, before
  // the address has been latched, so the read address bypasses addr_q.
  assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;

`ifdef IMEM_RANGE_CHECK_EN
  logic [29:0] rd_off;
  logic [29:0] wr_off;
  logic        rd_oor;

  // Addresses below BASE wrap to a huge offset and so fail the bound check.
  assign rd_off = rd_addr - BASE;
  assign wr_off = wr_addr - BASE;
  assign rd_oor = (rd_off >= 30'(DEPTH));
  assign wr_ok  = (wr_off < 30'(DEPTH));
  assign rd_idx = rd_off[ADDR_W-1:0];
  assign wr_idx = wr_off[ADDR_W-1:0];
`else
  // Without the range check the offset simply aliases onto the RAM.
  assign rd_idx = ADDR_W'(rd_addr - BASE);
  assign wr_idx = ADDR_W'(wr_addr - BASE);
  assign wr_ok  = 1'b1;
  assign fault  = 1'b0;
`endif

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // The PC is held while waiting and on the accept cycle; it is released in
  // RESP so the PC advances on the response cycle. Reset forces it low.
  assign stall = reset & ((state_q == WAIT) | accept);

  assign rsp_valid = (state_q == RESP);

  // Next-state logic: IDLE accepts, WAIT counts down wait states or aborts on
  // flush, RESP always returns to IDLE and ignores flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          cnt_d   = LAT4;
          state_d = (LAT4 == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM, wait counter and latched fetch address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= BASE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Response registers load on the edge that enters RESP and hold until the
  // next one; the RAM read sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_instr <= 32'h0;
      rsp_addr  <= BASE;
`ifdef IMEM_RANGE_CHECK_EN
      fault     <= 1'b0;
`endif
    end else if (enter_resp) begin
      rsp_addr  <= rd_addr;
`ifdef IMEM_RANGE_CHECK_EN
      rsp_instr <= rd_oor ? 32'h0 : mem[rd_idx];
      fault     <= rd_oor;
`else
      rsp_instr <= mem[rd_idx];
`endif
    end
  end

  // Preload write port; independent of the FSM and never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// tb_imem_fetch_resp: self-checking bench for imem_fetch_resp.
// A cycle-numbered reference model (pending fetch + scheduled response cycle
// + word array) predicts every output each cycle. A vector table covers the
// basic, back-to-back and flush sequences; hand-written sequences cover reset
// mid-wait, read/write collision and out-of-range fetches; then random traffic.
// Honours IMEM_RANGE_CHECK_EN the same way the design does.

module tb_imem_fetch_resp;

  localparam int          LAT   = 2;
  localparam logic [29:0] BASE  = 30'h0000C00;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:2] req_addr;
  logic        flush;
  logic        wr_en;
  logic [31:2] wr_addr;
  logic [31:0] wr_data;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:2] rsp_addr;
  logic        fault;

  imem_fetch_resp #(
    .ADDR_W (10),
    .LATENCY(LAT),
    .BASE   (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .stall    (stall),
    .rsp_valid(rsp_valid),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // Reference model state
  bit          m_pend;
  int          m_resp;
  logic [29:0] m_paddr;
  logic [31:0] m_instr;
  logic [29:0] m_raddr;
  logic        m_fault;
  logic [31:0] mem_model [DEPTH];

  // Outputs sampled in the most recent cycle
  logic        s_stall;
  logic        s_rv;
  logic        s_fault;
  logic [31:0] s_instr;
  logic [29:0] s_addr;

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [29:0] ra;
    logic        fl;
    logic        e_stall;
    logic        e_rv;
    logic [31:0] e_instr;
    logic [29:0] e_addr;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic rv, input logic [29:0] ra,
                               input logic fl, input logic we, input logic [29:0] wa,
                               input logic [31:0] wd);
    reset     = rst_n;
    req_valid = rv;
    req_addr  = ra;
    flush     = fl;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  // Fetch result as the RAM rules define it: offset from BASE, range-checked
  // or aliased depending on the build.
  task automatic modelCapture(input logic [29:0] a);
    logic [29:0] off;
    off     = a - BASE;
    m_raddr = a;
`ifdef IMEM_RANGE_CHECK_EN
    if (off >= 30'(DEPTH)) begin
      m_instr = 32'h0;
      m_fault = 1'b1;
    end else begin
      m_instr = mem_model[off[9:0]];
      m_fault = 1'b0;
    end
`else
    m_instr = mem_model[off[9:0]];
    m_fault = 1'b0;
`endif
  endtask

  task automatic modelWrite(input logic [29:0] a, input logic [31:0] d);
    logic [29:0] off;
    off = a - BASE;
`ifdef IMEM_RANGE_CHECK_EN
    if (off < 30'(DEPTH)) mem_model[off[9:0]] = d;
`else
    mem_model[off[9:0]] = d;
`endif
  endtask

  // Advance the model across one rising edge.
  task automatic modelEdge(input logic rst_n, input logic rv, input logic [29:0] ra,
                           input logic fl, input logic we, input logic [29:0] wa,
                           input logic [31:0] wd);
    if (!rst_n) begin
      m_pend  = 1'b0;
      m_instr = 32'h0;
      m_raddr = BASE;
      m_fault = 1'b0;
    end else begin
      if (m_pend && cyc < m_resp && fl) begin
        m_pend = 1'b0;
      end else if (m_pend && cyc == m_resp) begin
        m_pend = 1'b0;
      end else if (!m_pend && rv && !fl) begin
        m_pend  = 1'b1;
        m_resp  = cyc + 1 + LAT;
        m_paddr = ra;
      end
      if (m_pend && m_resp == cyc + 1) modelCapture(m_paddr);
    end
    if (we) modelWrite(wa, wd);
  endtask

  // One clock cycle: drive inputs, predict, sample at the falling edge,
  // compare, then step the model across the rising edge.
  task automatic runCycle(input logic rst_n, input logic rv, input logic [29:0] ra,
                          input logic fl, input logic we, input logic [29:0] wa,
                          input logic [31:0] wd);
    logic exp_stall;
    logic exp_rv;
    applyStimulus(rst_n, rv, ra, fl, we, wa, wd);
    exp_rv    = m_pend && (cyc == m_resp);
    exp_stall = rst_n && ((m_pend && cyc < m_resp) || (!m_pend && rv && !fl));
    @(negedge clk);
    s_stall = stall;
    s_rv    = rsp_valid;
    s_instr = rsp_instr;
    s_addr  = rsp_addr;
    s_fault = fault;
    checkOutput("stall", 32'(s_stall), 32'(exp_stall));
    checkOutput("rsp_valid", 32'(s_rv), 32'(exp_rv));
    checkOutput("rsp_instr", s_instr, m_instr);
    checkOutput("rsp_addr", 32'(s_addr), 32'(m_raddr));
    checkOutput("fault", 32'(s_fault), 32'(m_fault));
    @(posedge clk);
    modelEdge(rst_n, rv, ra, fl, we, wa, wd);
    #1;
    cyc++;
  endtask

  // Full fetch from IDLE: accept, LAT wait cycles (optional write on the last
  // one, i.e. on the RESP-entry edge), RESP, then one idle cycle.
  task automatic fetch(input logic [29:0] a, input logic wr_last, input logic [31:0] wd,
                       output logic rv, output logic [31:0] instr, output logic flt);
    runCycle(1'b1, 1'b1, a, 1'b0, 1'b0, 30'h0, 32'h0);
    for (int w = 0; w < LAT; w++)
      runCycle(1'b1, 1'b1, a, 1'b0, wr_last && (w == LAT - 1), a, wd);
    runCycle(1'b1, 1'b1, a, 1'b0, 1'b0, 30'h0, 32'h0);
    rv    = s_rv;
    instr = s_instr;
    flt   = s_fault;
    runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0);
  endtask

  function automatic logic [29:0] randAddr();
    int unsigned p;
    p = $urandom_range(99);
    if (p < 60)      return BASE + 30'($urandom_range(15));
    else if (p < 75) return BASE + 30'($urandom_range(DEPTH - 1));
    else if (p < 88) return BASE + 30'(DEPTH) + 30'($urandom_range(7));
    else             return BASE - 30'd1 - 30'($urandom_range(7));
  endfunction

  initial begin
    logic        f_rv;
    logic        f_flt;
    logic [31:0] f_instr;

    vecs[0]  = '{1'b1, 1'b1, 30'hC00, 1'b0, 1'b1, 1'b0, 32'h0,         30'hC00};
    vecs[1]  = '{1'b1, 1'b1, 30'hC00, 1'b0, 1'b1, 1'b0, 32'h0,         30'hC00};
    vecs[2]  = '{1'b1, 1'b1, 30'hC00, 1'b0, 1'b1, 1'b0, 32'h0,         30'hC00};
    vecs[3]  = '{1'b1, 1'b1, 30'hC00, 1'b0, 1'b0, 1'b1, 32'h3C01_0001, 30'hC00};
    vecs[4]  = '{1'b1, 1'b1, 30'hC01, 1'b0, 1'b1, 1'b0, 32'h3C01_0001, 30'hC00};
    vecs[5]  = '{1'b1, 1'b1, 30'hC01, 1'b0, 1'b1, 1'b0, 32'h3C01_0001, 30'hC00};
    vecs[6]  = '{1'b1, 1'b1, 30'hC01, 1'b0, 1'b1, 1'b0, 32'h3C01_0001, 30'hC00};
    vecs[7]  = '{1'b1, 1'b1, 30'hC01, 1'b0, 1'b0, 1'b1, 32'h3C02_0002, 30'hC01};
    vecs[8]  = '{1'b1, 1'b0, 30'hC01, 1'b0, 1'b0, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[9]  = '{1'b1, 1'b1, 30'hC02, 1'b0, 1'b1, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[10] = '{1'b1, 1'b1, 30'hC02, 1'b1, 1'b1, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[11] = '{1'b1, 1'b1, 30'hC02, 1'b1, 1'b0, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[12] = '{1'b1, 1'b1, 30'hC02, 1'b0, 1'b1, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[13] = '{1'b1, 1'b1, 30'hC02, 1'b0, 1'b1, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[14] = '{1'b1, 1'b1, 30'hC02, 1'b0, 1'b1, 1'b0, 32'h3C02_0002, 30'hC01};
    vecs[15] = '{1'b1, 1'b1, 30'hC02, 1'b1, 1'b0, 1'b1, 32'hDEAD_0C02, 30'hC02};
    vecs[16] = '{1'b1, 1'b0, 30'hC02, 1'b0, 1'b0, 1'b0, 32'hDEAD_0C02, 30'hC02};

    m_pend  = 1'b0;
    m_resp  = 0;
    m_paddr = BASE;
    m_instr = 32'h0;
    m_raddr = BASE;
    m_fault = 1'b0;

    // First reset edge brings the DUT to a known state.
    applyStimulus(1'b0, 1'b1, 30'hC00, 1'b0, 1'b0, 30'h0, 32'h0);
    @(posedge clk);
    #1;

    // Reset held with a request present: stall forced low, reset values.
    runCycle(1'b0, 1'b1, 30'hC00, 1'b0, 1'b0, 30'h0, 32'h0);
    checkOutput("rst_stall", 32'(s_stall), 32'h0);
    checkOutput("rst_rv", 32'(s_rv), 32'h0);
    checkOutput("rst_instr", s_instr, 32'h0);
    checkOutput("rst_addr", 32'(s_addr), 32'h0000_0C00);
    checkOutput("rst_fault", 32'(s_fault), 32'h0);

    // Preload every word, then the words the directed sequences rely on.
    for (int i = 0; i < DEPTH; i++)
      runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b1, BASE + 30'(i), $urandom());
    runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 30'hC00, 32'h3C01_0001);
    runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 30'hC01, 32'h3C02_0002);
    runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 30'hC02, 32'hDEAD_0C02);
    runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 30'hC03, 32'h1111_0C03);

    // Basic, back-to-back, flush-in-WAIT, req+flush in IDLE, flush-in-RESP.
    for (int i = 0; i < 17; i++) begin
      runCycle(vecs[i].rst_n, vecs[i].rv, vecs[i].ra, vecs[i].fl, 1'b0, 30'h0, 32'h0);
      checkOutput($sformatf("tbl%0d_stall", i), 32'(s_stall), 32'(vecs[i].e_stall));
      checkOutput($sformatf("tbl%0d_rv", i), 32'(s_rv), 32'(vecs[i].e_rv));
      checkOutput($sformatf("tbl%0d_instr", i), s_instr, vecs[i].e_instr);
      checkOutput($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(vecs[i].e_addr));
    end

    // Reset during WAIT: fetch dropped, outputs return to reset values.
    runCycle(1'b1, 1'b1, 30'hC03, 1'b0, 1'b0, 30'h0, 32'h0);
    runCycle(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0);
    for (int i = 0; i < LAT + 1; i++) begin
      runCycle(1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0);
      checkOutput("midwait_rv", 32'(s_rv), 32'h0);
      checkOutput("midwait_instr", s_instr, 32'h0);
      checkOutput("midwait_addr", 32'(s_addr), 32'h0000_0C00);
    end

    // Collision: write on the RESP-entry edge returns the old word.
    fetch(30'hC03, 1'b1, 32'h2222_0C03, f_rv, f_instr, f_flt);
    checkOutput("coll_rv", 32'(f_rv), 32'h1);
    checkOutput("coll_old", f_instr, 32'h1111_0C03);
    fetch(30'hC03, 1'b0, 32'h0, f_rv, f_instr, f_flt);
    checkOutput("coll_new", f_instr, 32'h2222_0C03);

    // Out-of-range fetches below BASE and past the end of the RAM.
    fetch(30'h0000BFF, 1'b0, 32'h0, f_rv, f_instr, f_flt);
    checkOutput("bff_rv", 32'(f_rv), 32'h1);
`ifdef IMEM_RANGE_CHECK_EN
    checkOutput("bff_instr", f_instr, 32'h0);
    checkOutput("bff_fault", 32'(f_flt), 32'h1);
`else
    checkOutput("bff_instr", f_instr, mem_model[DEPTH-1]);
    checkOutput("bff_fault", 32'(f_flt), 32'h0);
`endif
    fetch(BASE + 30'(DEPTH), 1'b0, 32'h0, f_rv, f_instr, f_flt);
    checkOutput("end_rv", 32'(f_rv), 32'h1);
`ifdef IMEM_RANGE_CHECK_EN
    checkOutput("end_instr", f_instr, 32'h0);
    checkOutput("end_fault", 32'(f_flt), 32'h1);
`else
    checkOutput("end_instr", f_instr, 32'h3C01_0001);
    checkOutput("end_fault", 32'(f_flt), 32'h0);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic        r_rst;
      logic        r_rv;
      logic        r_fl;
      logic        r_we;
      logic [29:0] r_ra;
      logic [29:0] r_wa;
      logic [31:0] r_wd;
      r_rst = ($urandom_range(199) != 0);
      r_rv  = ($urandom_range(99) < 70);
      r_fl  = ($urandom_range(99) < 10);
      r_we  = r_rst && ($urandom_range(99) < 25);
      r_ra  = randAddr();
      r_wa  = randAddr();
      r_wd  = $urandom();
      runCycle(r_rst, r_rv, r_ra, r_fl, r_we, r_wa, r_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
